// File: rtl/i2s_tdm_stream_port.sv
// i2s_tdm_stream_port: I2S/TDM master port with MCLK/SCLK/LRCK generation and AXI-stream tx/rx.
module i2s_tdm_stream_port #(
    parameter int DATA_W    = 24,
    parameter int SLOT_W    = 32,
    parameter int CHANNELS  = 2,
    parameter int SCLK_HALF = 4,
    parameter int MCLK_HALF = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              loopback,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              tx_underrun,
    output logic              tx_sync_err,
    output logic              rx_overrun,
    output logic              mclk,
    output logic              sclk,
    output logic              lrck,
    output logic              sdout,
    input  logic              sdin
);
    localparam int FRAME = CHANNELS * SLOT_W;
    localparam int QW = $clog2(SLOT_W);
    localparam int CW = $clog2(CHANNELS);
    localparam int DW = $clog2(SCLK_HALF);
    localparam int MW = MCLK_HALF > 1 ? $clog2(MCLK_HALF) : 1;
    localparam logic [QW-1:0] Q_MAX = QW'(SLOT_W - 1);
    localparam logic [CW-1:0] C_MAX = CW'(CHANNELS - 1);
    localparam logic [CW-1:0] C_HALF = CW'(CHANNELS / 2);
    localparam logic [DW-1:0] D_MAX = DW'(SCLK_HALF - 1);
    localparam logic [MW-1:0] M_MAX = MW'(MCLK_HALF - 1);

    logic [MW-1:0]     mclk_cnt;
    logic [DW-1:0]     div;
    logic [QW-1:0]     q, q_n;
    logic [CW-1:0]     c, c_n;
    logic [DATA_W-1:0] stage [CHANNELS];
    logic [CW-1:0]     idx;
    logic              full;
    logic [FRAME-1:0]  tx_sr, load_word;
    logic [SLOT_W-2:0] rx_sr;
    logic [SLOT_W-1:0] rx_word;
    logic              rx_live, tick, fall, rise, load, s_acc, rx_bit, slot_done;

    // Bit position p is kept as slot index c and bit-in-slot q, so p = c*SLOT_W + q.
    assign tick      = en && div == D_MAX;
    assign fall      = tick && sclk;
    assign rise      = tick && !sclk;
    assign load      = fall && q == '0 && c == '0;
    assign q_n       = q == Q_MAX ? '0 : q + 1'b1;
    assign c_n       = q != Q_MAX ? c : c == C_MAX ? '0 : c + 1'b1;
    assign s_acc     = s_axis_tvalid && s_axis_tready;
    assign rx_bit    = loopback ? sdout : sdin;
    assign rx_word   = {rx_sr, rx_bit};
    assign slot_done = rise && rx_live && q == '0;
    assign sdout     = tx_sr[FRAME-1];
    assign s_axis_tready = !full;

    always_comb begin
        load_word = '0;
        for (int k = 0; k < CHANNELS; k++)
            load_word[FRAME-1-k*SLOT_W -: DATA_W] = full ? stage[k] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mclk_cnt <= '0;
            mclk     <= 1'b0;
        end else begin
            mclk_cnt <= mclk_cnt == M_MAX ? '0 : mclk_cnt + 1'b1;
            mclk     <= mclk_cnt == M_MAX ? !mclk : mclk;
        end
    end

    // rx_live suppresses the slot "ending" on the very first rise after enable, which held no data.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div     <= '0;
            sclk    <= 1'b0;
            q       <= '0;
            c       <= '0;
            lrck    <= 1'b0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            rx_live <= 1'b0;
        end else begin
            div     <= tick ? '0 : div + 1'b1;
            sclk    <= tick ? !sclk : sclk;
            rx_live <= rx_live || rise;
            if (rise) rx_sr <= rx_word[SLOT_W-2:0];
            if (fall) begin
                q     <= q_n;
                c     <= c_n;
                lrck  <= c_n >= C_HALF;
                tx_sr <= load ? load_word : {tx_sr[FRAME-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < CHANNELS; k++) stage[k] <= '0;
            idx         <= '0;
            full        <= 1'b0;
            tx_underrun <= 1'b0;
            tx_sync_err <= 1'b0;
        end else begin
            tx_underrun <= load && !full;
            tx_sync_err <= s_acc && (s_axis_tlast != (idx == C_MAX));
            if (load && full) begin
                for (int k = 0; k < CHANNELS; k++) stage[k] <= '0;
                idx  <= '0;
                full <= 1'b0;
            end else if (s_acc && s_axis_tlast && idx != C_MAX) begin
                for (int k = 0; k < CHANNELS; k++) stage[k] <= '0;
                idx <= '0;
            end else if (s_acc) begin
                stage[idx] <= s_axis_tdata;
                idx        <= idx == C_MAX ? '0 : idx + 1'b1;
                full       <= idx == C_MAX;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_overrun <= slot_done && m_axis_tvalid && !m_axis_tready;
            if (slot_done) begin
                m_axis_tdata  <= rx_word[SLOT_W-1 -: DATA_W];
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= c == '0;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/i2s_tdm_stream_port.md
Name: i2s_tdm_stream_port

Overview:
- Native I2S/TDM master port with parametrised sample width, slot width, channel count and bit-clock ratio.
- Generates MCLK, SCLK and LRCK from clk.
- Serialises an AXI-stream of per-channel samples onto sdout and deserialises sdin into an AXI-stream.
- Sits between the audio DSP chain (overdrive etc.) and the Pmod codec; supersedes the fixed 24-bit stereo controller, adding frame buffering, error flags, loopback and enable.

Parameters:
DATA_W, 24, sample width on both streams.
SLOT_W, 32, SCLK periods per channel slot; must be >= DATA_W.
CHANNELS, 2, channels per frame; even, >= 2. 2 gives I2S; >2 gives TDM with 50% LRCK.
SCLK_HALF, 4, clk cycles per SCLK half-period; must be >= 2.
MCLK_HALF, 1, clk cycles per MCLK half-period.

Ports:
clk  in  1  system clock (22.5792 MHz nominal)
rst  in  1  reset
en  in  1  port enable
loopback  in  1  1: rx path uses internal sdout instead of sdin
s_axis_tdata  in  DATA_W  tx sample, two's complement
s_axis_tvalid  in  1  tx valid
s_axis_tready  out  1  tx ready
s_axis_tlast  in  1  marks channel CHANNELS-1
m_axis_tdata  out  DATA_W  rx sample
m_axis_tvalid  out  1  rx valid
m_axis_tready  in  1  rx ready
m_axis_tlast  out  1  high with channel CHANNELS-1
tx_underrun  out  1  1-cycle pulse
tx_sync_err  out  1  1-cycle pulse
rx_overrun  out  1  1-cycle pulse
mclk, sclk, lrck, sdout  out  1 each  codec interface
sdin  in  1  codec serial data

Behaviour:
- Reset: rst is synchronous, active-high, on clock clk. All outputs 0 except s_axis_tready=1. All counters 0, staging and shift register cleared.
- Timing: FRAME = CHANNELS*SLOT_W.
  - mclk toggles every MCLK_HALF clk cycles, free-running whenever not in reset.
  - While en=1, a divider toggles sclk every SCLK_HALF cycles.
  - Bit counter p (0..FRAME-1, wraps) advances on each sclk falling edge.
  - lrck = 1 when p >= FRAME/2, else 0; it changes on the falling edge.
- en=0 (including mid-frame): next cycle sclk, lrck, sdout = 0 and divider and p = 0. Staging and the rx output register are retained. On re-enable, the frame restarts at p=0.
- Slot mapping (I2S one-bit delay): slot k occupies p = k*SLOT_W+1 .. (k+1)*SLOT_W, modulo FRAME. MSB first. The first DATA_W bits carry the sample; the remaining slot bits are tx 0 and ignored on rx.
- Tx staging: CHANNELS-entry register plus write index.
  - s_axis_tready = 1 while staging is not complete.
  - Each accepted beat writes at the index, then the index increments.
  - tlast on index < CHANNELS-1: staging is discarded, index returns to 0, tx_sync_err pulses.
  - No tlast on index CHANNELS-1: the sample is still accepted, staging completes, tx_sync_err pulses.
- Tx load point: the falling edge entering p=1.
  - Staging complete: copy staging to the FRAME-bit shift register, clear staging, set tready=1 the next cycle.
  - Staging incomplete: load zeros, keep any partial staging, pulse tx_underrun.
  - sdout = shift-register MSB, shifting on each falling edge. The bit at p=0 is the previous frame's final LSB.
- Rx:
  - The rx bit source is sdin, or internal sdout when loopback=1.
  - It is sampled in the clk cycle where sclk rises.
  - When the last bit of slot k is sampled, the slot's top DATA_W bits go to m_axis_tdata one cycle later, with m_axis_tvalid=1 and m_axis_tlast=(k==CHANNELS-1).
  - The rx output holds until tvalid&&tready.
  - A new slot completing while tvalid=1 and not accepted that cycle: the new sample overwrites the old one and rx_overrun pulses.
  - Simultaneous accept and new slot: no overrun, and tvalid stays 1 with the new data.
- Simultaneous events:
  - An s_axis accept in the load-point cycle writes to the newly cleared staging at index 0.
  - rst overrides en, and en overrides loopback.

Test Plan:
- Defaults, en=1, no tx stimulus: sclk period = 8 clk, lrck period = 512 clk, mclk period = 2 clk. tx_underrun pulses once per frame; sdout stays 0.
- Loopback=1, stream L=0x123456, R=0xABCDEF with tlast on R, m_axis_tready=1: m_axis returns 0x123456 (tlast=0) then 0xABCDEF (tlast=1) in the following frame, with no error pulses.
- External sdin driven with the I2S pattern for L=0x800001, R=0x7FFFFF: m_axis outputs exactly these values, and lrck=0 during the L bits.
- tlast on the first beat (CHANNELS=2): tx_sync_err pulses and the index resets; the next two-beat frame transmits correctly.
- m_axis_tready=0 across 3 slots: rx_overrun pulses twice, and the held data equals the third slot.
- en dropped mid-frame at p=20, then raised: outputs go low the next cycle, and the frame restarts with lrck=0 and p=0. Repeat with rst asserted: every output returns to its reset value in the next cycle.
